// File: rtl/hwpe_tcdm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hwpe_tcdm_port_arbiter
//  Purpose  : Round-robin merge of N_IN HWPE TCDM master ports onto a single
//             TCDM slave port, with single-cycle response routing, per-port
//             saturating grant counters and a sticky stray-response flag.
//  Revision : 1.0 - initial release
// ============================================================================
module hwpe_tcdm_port_arbiter #(
  parameter int N_IN   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic [N_IN-1:0]            in_req_i,
  output logic [N_IN-1:0]            in_gnt_o,
  input  logic [N_IN*ADDR_W-1:0]     in_add_i,
  input  logic [N_IN-1:0]            in_wen_i,
  input  logic [N_IN*DATA_W/8-1:0]   in_be_i,
  input  logic [N_IN*DATA_W-1:0]     in_data_i,
  output logic [N_IN-1:0]            in_r_valid_o,
  output logic [DATA_W-1:0]          in_r_data_o,
  output logic                       out_req_o,
  input  logic                       out_gnt_i,
  output logic [ADDR_W-1:0]          out_add_o,
  output logic                       out_wen_o,
  output logic [DATA_W/8-1:0]        out_be_o,
  output logic [DATA_W-1:0]          out_data_o,
  input  logic                       out_r_valid_i,
  input  logic [DATA_W-1:0]          out_r_data_i,
  output logic [N_IN*CNT_W-1:0]      grant_cnt_o,
  output logic                       protocol_err_o
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int BE_W  = DATA_W / 8;

  logic [IDX_W-1:0] rr_ptr;
  logic             resp_pending;
  logic [IDX_W-1:0] resp_id;
  logic             err_flag;
  logic [CNT_W-1:0] cnt [N_IN];

  logic [IDX_W-1:0] winner;
  logic             found;
  logic             handshake;
  logic [IDX_W-1:0] next_ptr;

  // Priority scan starting at rr_ptr; payload follows the winner (port 0 when idle).
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    out_add_o  = in_add_i[ADDR_W-1:0];
    out_wen_o  = in_wen_i[0];
    out_be_o   = in_be_i[BE_W-1:0];
    out_data_o = in_data_i[DATA_W-1:0];
    for (int k = 0; k < N_IN; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        // rr_ptr+k stays below 2*N_IN, so one conditional subtraction wraps it.
        if (!found && in_req_i[i] &&
            (((int'(rr_ptr) + k) < N_IN) ? (int'(rr_ptr) + k) : (int'(rr_ptr) + k - N_IN)) == i) begin
          found      = 1'b1;
          winner     = IDX_W'(i);
          out_add_o  = in_add_i[i*ADDR_W +: ADDR_W];
          out_wen_o  = in_wen_i[i];
          out_be_o   = in_be_i[i*BE_W +: BE_W];
          out_data_o = in_data_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign out_req_o   = |in_req_i;
  assign handshake   = out_req_o & out_gnt_i;
  assign next_ptr    = (winner == IDX_W'(N_IN - 1)) ? '0 : winner + 1'b1;
  assign in_r_data_o = out_r_data_i;
  assign protocol_err_o = err_flag;

  // Grant steering, response routing and counter packing per port.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      in_gnt_o[i]     = out_req_o & out_gnt_i & (winner == IDX_W'(i));
      in_r_valid_o[i] = out_r_valid_i & resp_pending & (resp_id == IDX_W'(i));
      grant_cnt_o[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  // Round-robin pointer and outstanding-response tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr       <= '0;
      resp_pending <= 1'b0;
      resp_id      <= '0;
    end else if (handshake) begin
      rr_ptr       <= next_ptr;
      resp_id      <= winner;
      resp_pending <= 1'b1;
    end else begin
      resp_pending <= 1'b0;
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_flag <= 1'b0;
    end else if (clear_i) begin
      err_flag <= 1'b0;
    end else if (out_r_valid_i && !resp_pending) begin
      err_flag <= 1'b1;
    end
  end

  // Saturating per-port grant counters; clear wins over a same-cycle grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (clear_i) begin
          cnt[i] <= '0;
        end else if (handshake && (winner == IDX_W'(i)) && (cnt[i] != {CNT_W{1'b1}})) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_tcdm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hwpe_tcdm_port_arbiter
//  Purpose  : Directed self-checking bench for hwpe_tcdm_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_tcdm_port_arbiter;

  localparam int N = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt_o;
  logic [N*AW-1:0] add;
  logic [N-1:0]    wen;
  logic [N*4-1:0]  be;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            oreq;
  logic            ognt;
  logic [AW-1:0]   oadd;
  logic            owen;
  logic [3:0]      obe;
  logic [DW-1:0]   odata;
  logic            orvalid;
  logic [DW-1:0]   ordata;
  logic [N*CW-1:0] cnt;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hwpe_tcdm_port_arbiter #(.N_IN(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_req_i(req), .in_gnt_o(gnt_o), .in_add_i(add), .in_wen_i(wen),
    .in_be_i(be), .in_data_i(wdata), .in_r_valid_o(rvalid_o), .in_r_data_o(rdata_o),
    .out_req_o(oreq), .out_gnt_i(ognt), .out_add_o(oadd), .out_wen_o(owen),
    .out_be_o(obe), .out_data_o(odata), .out_r_valid_i(orvalid), .out_r_data_i(ordata),
    .grant_cnt_o(cnt), .protocol_err_o(err)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; req = '0; ognt = 1'b0; orvalid = 1'b0; ordata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; ognt = 1'b1; orvalid = 1'b0;
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", cnt); end
    n_checks++; if (rvalid_o !== '0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 000", rvalid_o); end
    n_checks++; if (oreq !== 1'b0) begin n_fail++; $display("FAIL reset_oreq: got %b expected 0", oreq); end
    n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt_o); end
    do_reset();
  endtask

  task automatic test_all_request();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = 3'b111; ognt = 1'b1; orvalid = (c > 0);
      #1;
      n_checks++;
      if (gnt_o !== 3'(1 << order[c])) begin
        n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt_o, 3'(1 << order[c]));
      end
      n_checks++;
      if (oadd !== 32'h1000_0000 + 32'(order[c] * 16)) begin
        n_fail++; $display("FAIL rr_addr c%0d: got %h expected %h", c, oadd, 32'h1000_0000 + 32'(order[c] * 16));
      end
      n_checks++;
      if (rvalid_o !== ((c > 0) ? 3'(1 << order[(c > 0) ? c - 1 : 0]) : 3'b000)) begin
        n_fail++; $display("FAIL rr_rvalid c%0d: got %b", c, rvalid_o);
      end
    end
    @(negedge clk);
    req = '0; ognt = 1'b0; orvalid = 1'b1;
    #1;
    n_checks++; if (rvalid_o !== 3'b100) begin n_fail++; $display("FAIL rr_last_rvalid: got %b expected 100", rvalid_o); end
    @(negedge clk);
    orvalid = 1'b0;
    n_checks++;
    if (cnt !== {16'd2, 16'd2, 16'd2}) begin n_fail++; $display("FAIL rr_counters: got %h expected 000200020002", cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b expected 0", err); end
  endtask

  task automatic test_single_port();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = 3'b100; ognt = 1'b1;
      #1;
      n_checks++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL p2_gnt c%0d: got %b expected 100", c, gnt_o); end
    end
    @(negedge clk);
    req = 3'b111; ognt = 1'b0;
    #1;
    n_checks++; if (cnt !== {16'd3, 16'd0, 16'd0}) begin n_fail++; $display("FAIL p2_counters: got %h expected 000300000000", cnt); end
    ognt = 1'b1;
    #1;
    n_checks++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL p2_ptr_stays0: got %b expected 001", gnt_o); end
    @(negedge clk);
    req = '0; ognt = 1'b0;
  endtask

  task automatic test_rotation();
    logic [N-1:0] reqs [4] = '{3'b011, 3'b011, 3'b101, 3'b101};
    logic [N-1:0] exps [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = reqs[c]; ognt = 1'b1;
      #1;
      n_checks++; if (gnt_o !== exps[c]) begin n_fail++; $display("FAIL rot_gnt c%0d: got %b expected %b", c, gnt_o, exps[c]); end
    end
    @(negedge clk);
    req = '0; ognt = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = 3'b010; ognt = 1'b0;
      #1;
      n_checks++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL stall_gnt c%0d: got %b expected 000", c, gnt_o); end
      n_checks++; if (oreq !== 1'b1 || oadd !== 32'h1000_0010) begin n_fail++; $display("FAIL stall_req c%0d: got %b/%h expected 1/10000010", c, oreq, oadd); end
    end
    @(negedge clk);
    ognt = 1'b1;
    #1;
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL stall_gnt5: got %b expected 010", gnt_o); end
    n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL stall_early_rvalid: got %b expected 000", rvalid_o); end
    @(negedge clk);
    req = '0; ognt = 1'b0; orvalid = 1'b1; ordata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (rvalid_o !== 3'b010) begin n_fail++; $display("FAIL stall_rvalid6: got %b expected 010", rvalid_o); end
    n_checks++; if (rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_rdata: got %h expected deadbeef", rdata_o); end
    @(negedge clk);
    orvalid = 1'b0;
    #1;
    n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL stall_rvalid7: got %b expected 000", rvalid_o); end
    n_checks++; if (cnt !== {16'd0, 16'd1, 16'd0} || err !== 1'b0) begin n_fail++; $display("FAIL stall_cnt_err: got %h/%b expected 000000010000/0", cnt, err); end
  endtask

  task automatic test_stray_response();
    do_reset();
    @(negedge clk);
    req = '0; ognt = 1'b0; orvalid = 1'b1; ordata = 32'h1234_5678;
    #1;
    n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL stray_fwd: got %b expected 000", rvalid_o); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stray_err_early: got %b expected 0", err); end
    @(negedge clk);
    orvalid = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_err_set: got %b expected 1", err); end
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_err_sticky: got %b expected 1", err); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stray_err_clear: got %b expected 0", err); end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    req = 3'b001; ognt = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cnt[15:0] !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected fffe", cnt[15:0]); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cnt[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", cnt[15:0]); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; req = '0; ognt = 1'b0;
    n_checks++; if (cnt[15:0] !== 16'h0000) begin n_fail++; $display("FAIL sat_clear_vs_grant: got %h expected 0000", cnt[15:0]); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    req = 3'b010; ognt = 1'b1;
    @(negedge clk);
    req = '0; ognt = 1'b0; rst = 1'b1; orvalid = 1'b1;
    #1;
    n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL mid_rvalid: got %b expected 000", rvalid_o); end
    n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL mid_cnt: got %h expected 0", cnt); end
    @(negedge clk);
    rst = 1'b0; orvalid = 1'b0;
    @(negedge clk);
    req = 3'b110; ognt = 1'b1;
    #1;
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL mid_first_gnt: got %b expected 010", gnt_o); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b expected 0", err); end
    @(negedge clk);
    req = '0; ognt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; req = '0; ognt = 1'b0; orvalid = 1'b0; ordata = '0;
    for (int i = 0; i < N; i++) begin
      add[i*AW +: AW]   = 32'h1000_0000 + 32'(i * 16);
      wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
      be[i*4 +: 4]      = 4'(4'hF >> i);
      wen[i]            = i[0];
    end
    test_reset();
    test_all_request();
    test_single_port();
    test_rotation();
    test_stall();
    test_stray_response();
    test_saturation();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hwpe_tcdm_port_arbiter.md
# hwpe_tcdm_port_arbiter

Round-robin arbiter that merges the HWPE's TCDM master ports (N_HWPE_PORTS, currently 3) onto one cluster TCDM slave port. It sits between the HWPE streamer and the cluster TCDM interconnect. It routes each single-cycle-latency response back to the port that issued the request. It also keeps per-port saturating grant counters for bandwidth profiling and flags responses that arrive with no request outstanding.

## Interface
- N_IN, 3, number of HWPE TCDM ports; must equal N_HWPE_PORTS; legal range 1..16
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enable width is DATA_W/8
- CNT_W, 16, width of each grant counter
- IDX_W, derived: max(1, $clog2(N_IN)), width of the port index

Ports:
- clk_i, in, 1, single clock; all state updates on its rising edge
- rst_i, in, 1, asynchronous active-high reset
- clear_i, in, 1, synchronous clear of the grant counters and the error flag
- in_req_i, in, N_IN, per-port request
- in_gnt_o, out, N_IN, per-port grant; one-hot or zero
- in_add_i, in, N_IN×ADDR_W, per-port address
- in_wen_i, in, N_IN, per-port write-enable; 1 = read, 0 = write (TCDM convention)
- in_be_i, in, N_IN×DATA_W/8, per-port byte enables
- in_data_i, in, N_IN×DATA_W, per-port write data
- in_r_valid_o, out, N_IN, per-port response valid; one-hot or zero
- in_r_data_o, out, DATA_W, response data, broadcast to all ports
- out_req_o, out, 1, request to TCDM
- out_gnt_i, in, 1, grant from TCDM
- out_add_o / out_wen_o / out_be_o / out_data_o, out, ADDR_W / 1 / DATA_W/8 / DATA_W, winner's fields
- out_r_valid_i, in, 1, TCDM response valid; arrives exactly 1 cycle after a req&gnt handshake
- out_r_data_i, in, DATA_W, TCDM response data
- grant_cnt_o, out, N_IN×CNT_W, per-port grant counters
- protocol_err_o, out, 1, sticky unexpected-response flag

## Operation
- State:
  - rr_ptr (IDX_W bits)
  - resp_pending (1 bit)
  - resp_id (IDX_W bits)
  - grant counters
  - err flag
- Arbitration is combinational. The winner is the first index i with in_req_i[i]=1, scanning rr_ptr, rr_ptr+1, …, wrapping from N_IN-1 to 0.
- out_req_o = OR of in_req_i. out_add_o, out_wen_o, out_be_o and out_data_o carry the winner's fields.
- With no requests pending, the payload outputs carry port 0's fields. Their value is don't-care when out_req_o=0.
- in_gnt_o[winner] = out_gnt_i. All other in_gnt_o bits are 0.
- On a handshake (out_req_o & out_gnt_i):
  - rr_ptr ← winner+1, wrapping to 0 after N_IN-1.
  - resp_id ← winner.
  - resp_pending ← 1.
- With no handshake, rr_ptr holds and resp_pending ← 0.
- in_r_valid_o[resp_id] = out_r_valid_i & resp_pending. All other bits are 0.
- in_r_data_o = out_r_data_i, unconditionally.
- Reads and writes both produce a response. Write responses are routed the same way.
- out_r_valid_i=1 while resp_pending=0 sets the err flag. The flag stays set until clear_i or reset. The stray response is not forwarded.
- Grant counters:
  - On a handshake, the winner's counter increments by 1, saturating at 2^CNT_W-1.
  - clear_i=1 zeroes all counters and the err flag, and takes priority over an increment in the same cycle.
  - clear_i does not affect arbitration or the response path.
- N_IN=1 degenerates to a pass-through: rr_ptr is constant 0 and the counter and error logic are kept.

## Timing
- Reset values:
  - rr_ptr=0, resp_pending=0, resp_id=0, counters=0, err=0.
  - Consequently protocol_err_o=0, grant_cnt_o=0 and in_r_valid_o=0 during and after reset.
  - out_req_o=0 and in_gnt_o=0 whenever in_req_i=0.
- Request to out_req_o, and out_gnt_i to in_gnt_o: 0 cycles (combinational).
- Response routing: in_r_valid_o for the port granted in cycle N asserts in cycle N+1, coincident with out_r_valid_i.
- Back-to-back grants on consecutive cycles are supported. The next handshake overwrites resp_id at the same edge the previous response is consumed.
- Counter and protocol_err_o updates are visible the cycle after the triggering event.
- Reset asserted mid-transaction drops the pending response.
- Ports hold their request until granted; the arbiter does not buffer requests.

## Test plan
- Ports 0, 1, 2 all request continuously with out_gnt_i=1 -> grant order 0,1,2,0,1,2. Each in_r_valid_o fires 1 cycle after its grant. After 6 cycles every counter reads 2.
- Only port 2 requests, rr_ptr=0, gnt=1 for 3 cycles -> port 2 is granted every cycle and rr_ptr stays 0. Counter 2 reads 3 and the other counters read 0.
- Port 1 requests with out_gnt_i=0 for 4 cycles, then 1 -> in_gnt_o stays 0 for 4 cycles. There is a single handshake on cycle 5 and a single in_r_valid_o[1] on cycle 6. out_r_data_i=0xDEADBEEF appears on in_r_data_o.
- out_r_valid_i pulsed with no prior handshake -> in_r_valid_o stays 0 and protocol_err_o=1 from the next cycle. clear_i then resets it to 0.
- Counter for port 0 preloaded to 0xFFFE by granting, then 3 more grants -> reads 0xFFFF and holds. clear_i in the same cycle as a grant -> reads 0.
- rst_i asserted the cycle after a handshake -> no in_r_valid_o and all state at reset values. The first grant after release goes to the lowest requesting index.
